// File: rtl/gcd_disp_pkg.sv
// gcd_disp_pkg
// Shared types and constants for the GCD display driver: the conversion FSM
// state encoding, active-low seven-segment codes (bit order g..a), the
// number of double-dabble shifts for a 5-bit input, and the add-3 helper.
package gcd_disp_pkg;

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    localparam int         NUM_SHIFTS = 5;
    localparam logic [2:0] LAST_SHIFT = 3'(NUM_SHIFTS - 1);

    // Double-dabble correction: a nibble of 5 or more would overflow past 9
    // after the next doubling, so pre-add 3.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/gcd_disp_driver_seg7_decode.sv
// seg7_decode
// Combinational BCD to seven-segment decoder, active-low outputs.
// Ports:
//   bcd   in  4  BCD digit value
//   blank in  1  force all segments off when high
//   seg   out 7  active-low segments, bit order g..a
// Codes above 9 are shown as a blank digit.
module seg7_decode
    import gcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/gcd_disp_driver.sv
// gcd_disp_driver
// Converts the 5-bit GCD result to BCD with a sequential double-dabble and
// drives a 4-digit multiplexed seven-segment display.
// Ports:
//   clk    in  1   clock, rising edge
//   reset  in  1   asynchronous reset, active low
//   result in  5   GCD value, valid while done is high
//   done   in  1   upstream completion flag; a rising edge starts conversion
//   disp   out 16  packed BCD digits (digit3..digit0), upper byte always 0
//   seg    out 7   active-low segments (g..a) for the selected digit
//   an     out 4   active-low one-hot digit enable, an[0] = digit0
//   busy   out 1   high while a conversion is running
// Parameter REFRESH_DIV: clocks each digit is driven (2..65535).
module gcd_disp_driver
    import gcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  result,
    input  logic        done,
    output logic [15:0] disp,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        busy
);

    localparam logic [15:0] REFRESH_MAX = 16'(REFRESH_DIV - 1);

    state_t      state_q, state_d;
    logic        done_q;
    logic        start;
    logic [4:0]  hold_q;
    logic [7:0]  bcd_q;
    logic [2:0]  shift_cnt_q;
    logic [7:0]  bcd_adj;
    logic [7:0]  bcd_next;
    logic [4:0]  hold_next;
    logic        conv_last;
    logic [7:0]  disp_lo_q;

    logic [15:0] refresh_q;
    logic [1:0]  digit_q;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_dec;
    logic [3:0]  digit_bcd;
    logic        digit_blank;

    assign start = done & ~done_q;

    // One double-dabble step: correct both nibbles, then shift the next
    // binary bit (MSB of the hold register) into the BCD accumulator.
    assign bcd_adj   = {add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    assign bcd_next  = {bcd_adj[6:0], hold_q[4]};
    assign hold_next = {hold_q[3:0], 1'b0};

    // A start on the final shift restarts instead, so the stale value is dropped.
    assign conv_last = (state_q == CONVERT) && (shift_cnt_q == LAST_SHIFT) && !start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q == CONVERT);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (start) begin
                    state_d = CONVERT;
                end else if (conv_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q      <= 1'b0;
            hold_q      <= '0;
            bcd_q       <= '0;
            shift_cnt_q <= '0;
            disp_lo_q   <= '0;
        end else begin
            done_q <= done;
            if (start) begin
                hold_q      <= result;
                bcd_q       <= '0;
                shift_cnt_q <= '0;
            end else if (state_q == CONVERT) begin
                hold_q      <= hold_next;
                bcd_q       <= bcd_next;
                shift_cnt_q <= shift_cnt_q + 3'd1;
                if (conv_last) begin
                    disp_lo_q <= bcd_next;
                end
            end
        end
    end

    // A 5-bit input never exceeds 31, so only two digits are ever non-zero.
    assign disp = {8'h00, disp_lo_q};

    // Digit selection: digits 3 and 2 are always blank, digit 1 blanks its
    // leading zero, digit 0 is always shown.
    always_comb begin
        digit_bcd   = 4'd0;
        digit_blank = 1'b1;
        an_d        = 4'hF;
        case (digit_q)
            2'd0: begin
                digit_bcd   = disp_lo_q[3:0];
                digit_blank = 1'b0;
                an_d        = 4'hE;
            end
            2'd1: begin
                digit_bcd   = disp_lo_q[7:4];
                digit_blank = (disp_lo_q[7:4] == 4'd0);
                an_d        = 4'hD;
            end
            2'd2: an_d = 4'hB;
            2'd3: an_d = 4'h7;
            default: an_d = 4'hF;
        endcase
    end

    seg7_decode u_seg7_decode (
        .bcd   (digit_bcd),
        .blank (digit_blank),
        .seg   (seg_dec)
    );

    // Scan runs free of the converter; an/seg are registered so reset can
    // hold the display dark.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_q <= '0;
            digit_q   <= '0;
            an_q      <= 4'hF;
            seg_q     <= SEG_BLANK;
        end else begin
            if (refresh_q == REFRESH_MAX) begin
                refresh_q <= '0;
                digit_q   <= digit_q + 2'd1;
            end else begin
                refresh_q <= refresh_q + 16'd1;
            end
            an_q  <= an_d;
            seg_q <= seg_dec;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule
